// File: rtl/tx_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream transmit path among NUM_QUEUES requesters.
// Grants are whole packets; queue_en masks requesters only at arbitration time.

module tx_rr_arbiter_chk #(
  parameter int NUM_QUEUES = 4,
  parameter int QID_WIDTH  = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic [QID_WIDTH-1:0]  rr_ptr,
  input logic [NUM_QUEUES-1:0] s_axis_tready
);
  localparam logic [QID_WIDTH:0] NQ_W = (QID_WIDTH+1)'(NUM_QUEUES);

  a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, rr_ptr} < NQ_W));

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(s_axis_tready));
endmodule

module tx_rr_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES         = 4,
  parameter int QID_WIDTH          = 3
) (
  input  logic                                          axis_aclk,
  input  logic                                          axis_resetn,
  input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                         s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                         s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                         s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
  output logic                                          m_axis_tvalid,
  output logic                                          m_axis_tlast,
  input  logic                                          m_axis_tready,
  input  logic [NUM_QUEUES-1:0]                         queue_en,
  output logic [QID_WIDTH-1:0]                          grant_id,
  output logic                                          pkt_sent,
  output logic [QID_WIDTH-1:0]                          pkt_sent_id
);
  localparam int DW    = C_AXIS_DATA_WIDTH;
  localparam int KW    = C_AXIS_DATA_WIDTH / 8;
  localparam int UW    = C_AXIS_TUSER_WIDTH;
  localparam int NSLOT = 1 << QID_WIDTH;
  localparam logic [QID_WIDTH-1:0] LAST_Q = QID_WIDTH'(NUM_QUEUES - 1);
  localparam logic [QID_WIDTH-1:0] ONE_Q  = QID_WIDTH'(1);
  localparam logic [QID_WIDTH:0]   NQ_W   = (QID_WIDTH+1)'(NUM_QUEUES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [1:0]           rst_sync_r;
  logic                 rst_n_s;
  logic [QID_WIDTH-1:0] grant_r;
  logic [QID_WIDTH-1:0] grant_nxt_s;
  logic [QID_WIDTH-1:0] rr_ptr_r;
  logic [QID_WIDTH-1:0] rr_ptr_nxt_s;
  logic                 pkt_sent_r;
  logic                 pkt_sent_nxt_s;
  logic [QID_WIDTH-1:0] pkt_sent_id_r;
  logic [QID_WIDTH-1:0] pkt_sent_id_nxt_s;
  logic                 found_s;
  logic [QID_WIDTH-1:0] pick_s;
  logic                 send_s;
  logic                 beat_last_s;

  // Per-queue views padded to a power of two so grant_r indexes them at exact width.
  logic [NSLOT*DW-1:0]  data_pad_s;
  logic [NSLOT*KW-1:0]  keep_pad_s;
  logic [NSLOT*UW-1:0]  user_pad_s;
  logic [NSLOT-1:0]     valid_pad_s;
  logic [NSLOT-1:0]     last_pad_s;
  logic [NSLOT-1:0]     cand_s;
  logic [NSLOT-1:0]     ready_pad_s;
  logic [DW-1:0]        data_arr_s [NSLOT];
  logic [KW-1:0]        keep_arr_s [NSLOT];
  logic [UW-1:0]        user_arr_s [NSLOT];

  assign data_pad_s  = (NSLOT*DW)'(s_axis_tdata);
  assign keep_pad_s  = (NSLOT*KW)'(s_axis_tkeep);
  assign user_pad_s  = (NSLOT*UW)'(s_axis_tuser);
  assign valid_pad_s = NSLOT'(s_axis_tvalid);
  assign last_pad_s  = NSLOT'(s_axis_tlast);
  assign cand_s      = NSLOT'(s_axis_tvalid & queue_en);

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    assign data_arr_s[g] = data_pad_s[g*DW +: DW];
    assign keep_arr_s[g] = keep_pad_s[g*KW +: KW];
    assign user_arr_s[g] = user_pad_s[g*UW +: UW];
  end

  // Reset asserts asynchronously and releases two clocks after axis_resetn rises.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];
  assign send_s  = (state_r == SEND);

  // First enabled requester at or above rr_ptr, wrapping modulo NUM_QUEUES.
  always_comb begin
    logic [QID_WIDTH:0] idx_v;
    idx_v   = '0;
    found_s = 1'b0;
    pick_s  = '0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      idx_v = {1'b0, rr_ptr_r} + (QID_WIDTH+1)'(k);
      if (idx_v >= NQ_W) begin
        idx_v = idx_v - NQ_W;
      end else begin
        idx_v = idx_v;
      end
      if (!found_s && cand_s[idx_v[QID_WIDTH-1:0]]) begin
        found_s = 1'b1;
        pick_s  = idx_v[QID_WIDTH-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Master side is a pure mux of the granted queue; everything reads zero outside SEND.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    ready_pad_s   = '0;
    if (send_s) begin
      m_axis_tdata         = data_arr_s[grant_r];
      m_axis_tkeep         = keep_arr_s[grant_r];
      m_axis_tuser         = user_arr_s[grant_r];
      m_axis_tvalid        = valid_pad_s[grant_r];
      m_axis_tlast         = last_pad_s[grant_r];
      ready_pad_s[grant_r] = m_axis_tready;
    end else begin
      ready_pad_s = '0;
    end
  end

  assign s_axis_tready = ready_pad_s[NUM_QUEUES-1:0];
  assign beat_last_s   = send_s & m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Next-state: grant in IDLE, release on the tlast handshake and advance the pointer.
  always_comb begin
    state_nxt_s       = state_r;
    grant_nxt_s       = grant_r;
    rr_ptr_nxt_s      = rr_ptr_r;
    pkt_sent_nxt_s    = 1'b0;
    pkt_sent_id_nxt_s = pkt_sent_id_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = SEND;
          grant_nxt_s = pick_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (beat_last_s) begin
          state_nxt_s       = IDLE;
          rr_ptr_nxt_s      = (grant_r == LAST_Q) ? '0 : (grant_r + ONE_Q);
          pkt_sent_nxt_s    = 1'b1;
          pkt_sent_id_nxt_s = grant_r;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge axis_aclk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r       <= IDLE;
      grant_r       <= '0;
      rr_ptr_r      <= '0;
      pkt_sent_r    <= 1'b0;
      pkt_sent_id_r <= '0;
    end else begin
      state_r       <= state_nxt_s;
      grant_r       <= grant_nxt_s;
      rr_ptr_r      <= rr_ptr_nxt_s;
      pkt_sent_r    <= pkt_sent_nxt_s;
      pkt_sent_id_r <= pkt_sent_id_nxt_s;
    end
  end

  assign grant_id    = grant_r;
  assign pkt_sent    = pkt_sent_r;
  assign pkt_sent_id = pkt_sent_id_r;

  tx_rr_arbiter_chk #(
    .NUM_QUEUES (NUM_QUEUES),
    .QID_WIDTH  (QID_WIDTH)
  ) u_chk (
    .clk           (axis_aclk),
    .rst_n         (rst_n_s),
    .rr_ptr        (rr_ptr_r),
    .s_axis_tready (s_axis_tready)
  );
endmodule

// File: tb/tb_tx_rr_arbiter.sv
// Self-checking bench for tx_rr_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a packet-level round-robin reference model.
module tb_tx_rr_arbiter;
  localparam int W  = 64;
  localparam int KW = 8;
  localparam int UW = 128;
  localparam int NQ = 4;
  localparam int QW = 3;

  logic            clk = 1'b0;
  logic            axis_resetn;
  logic [NQ*W-1:0]  s_axis_tdata;
  logic [NQ*KW-1:0] s_axis_tkeep;
  logic [NQ*UW-1:0] s_axis_tuser;
  logic [NQ-1:0]   s_axis_tvalid;
  logic [NQ-1:0]   s_axis_tlast;
  logic [NQ-1:0]   s_axis_tready;
  logic [W-1:0]    m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic [UW-1:0]   m_axis_tuser;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tready;
  logic [NQ-1:0]   queue_en;
  logic [QW-1:0]   grant_id;
  logic            pkt_sent;
  logic [QW-1:0]   pkt_sent_id;

  always #5 clk = ~clk;

  tx_rr_arbiter #(
    .C_AXIS_DATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(UW), .NUM_QUEUES(NQ), .QID_WIDTH(QW)
  ) dut (
    .axis_aclk(clk), .axis_resetn(axis_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .queue_en(queue_en), .grant_id(grant_id), .pkt_sent(pkt_sent), .pkt_sent_id(pkt_sent_id)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t mem [NQ][512];
  int    head [NQ];
  int    tail [NQ];

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, where the next search starts, pending pkt_sent.
  bit m_busy;
  int m_grant;
  int m_ptr;
  bit m_sent;
  int m_sent_id;
  int grant_log[$];
  int grant_cyc[$];
  int cyc = 0;
  int beats_out = 0;

  logic [NQ-1:0] en_knob = 4'hF;
  bit            tready_knob = 1'b1;
  bit            tready_rand = 1'b0;
  int            gap_pct = 0;

  function automatic int rr_pick(int ptr, logic [NQ-1:0] cand);
    for (int k = 0; k < NQ; k++) begin
      int q;
      q = (ptr + k) % NQ;
      if (cand[q]) return q;
    end
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int q = 0; q < NQ; q++) if (head[q] < tail[q]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int q = 0; q < NQ; q++) begin head[q] = 0; tail[q] = 0; end
    m_busy = 1'b0; m_grant = 0; m_ptr = 0; m_sent = 1'b0; m_sent_id = 0;
    grant_log.delete(); grant_cyc.delete();
  endtask

  task automatic push_pkt(int q, int len);
    for (int b = 0; b < len; b++) begin
      beat_t x;
      x.data = {$urandom(), $urandom()};
      x.keep = 8'($urandom());
      x.user = {$urandom(), $urandom(), $urandom(), $urandom()};
      x.last = (b == len - 1);
      mem[q][tail[q]] = x;
      tail[q]++;
    end
  endtask

  task automatic drive();
    for (int q = 0; q < NQ; q++) begin
      beat_t b;
      bit    has;
      has = head[q] < tail[q];
      if (has) b = mem[q][head[q]];
      else begin
        b.data = {$urandom(), $urandom()};
        b.keep = 8'($urandom());
        b.user = {$urandom(), $urandom(), $urandom(), $urandom()};
        b.last = 1'($urandom());
      end
      s_axis_tvalid[q]         = has && (int'($urandom_range(99)) >= gap_pct);
      s_axis_tdata[q*W +: W]   = b.data;
      s_axis_tkeep[q*KW +: KW] = b.keep;
      s_axis_tuser[q*UW +: UW] = b.user;
      s_axis_tlast[q]          = b.last;
    end
    queue_en      = en_knob;
    m_axis_tready = tready_rand ? (int'($urandom_range(99)) < 70) : tready_knob;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model over the rising edge.
  task automatic step();
    logic [NQ-1:0] exp_ready;
    logic [NQ-1:0] cand;
    bit            hs;
    int            pick;
    beat_t         b;
    @(negedge clk);
    checks++;
    if (pkt_sent !== m_sent) begin
      errors++; $display("FAIL pkt_sent cyc=%0d: got %b expected %b", cyc, pkt_sent, m_sent);
    end
    if (m_sent) begin
      checks++;
      if (pkt_sent_id !== QW'(m_sent_id)) begin
        errors++; $display("FAIL pkt_sent_id cyc=%0d: got %0d expected %0d", cyc, pkt_sent_id, m_sent_id);
      end
    end
    checks++;
    if (grant_id !== QW'(m_grant)) begin
      errors++; $display("FAIL grant_id cyc=%0d: got %0d expected %0d", cyc, grant_id, m_grant);
    end
    if (!m_busy) begin
      checks++;
      if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || m_axis_tdata !== '0 ||
          m_axis_tkeep !== '0 || m_axis_tuser !== '0 || m_axis_tlast !== 1'b0) begin
        errors++; $display("FAIL idle_outputs cyc=%0d: got valid=%b ready=%b data=%h last=%b expected all zero",
                           cyc, m_axis_tvalid, s_axis_tready, m_axis_tdata, m_axis_tlast);
      end
    end else begin
      exp_ready = '0;
      if (m_axis_tready) exp_ready[m_grant] = 1'b1;
      checks++;
      if (s_axis_tready !== exp_ready) begin
        errors++; $display("FAIL s_tready cyc=%0d: got %b expected %b", cyc, s_axis_tready, exp_ready);
      end
      checks++;
      if (m_axis_tvalid !== s_axis_tvalid[m_grant]) begin
        errors++; $display("FAIL m_tvalid cyc=%0d: got %b expected %b", cyc, m_axis_tvalid, s_axis_tvalid[m_grant]);
      end
      if (s_axis_tvalid[m_grant]) begin
        b = mem[m_grant][head[m_grant]];
        checks++;
        if ({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} !== b) begin
          errors++; $display("FAIL beat q%0d cyc=%0d: got %h/%h/%h/%b expected %h/%h/%h/%b", m_grant, cyc,
                             m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, b.data, b.keep, b.user, b.last);
        end
      end
    end
    cand = s_axis_tvalid & queue_en;
    hs   = m_busy && s_axis_tvalid[m_grant] && (m_axis_tready === 1'b1);
    @(posedge clk);
    cyc++;
    m_sent = 1'b0;
    if (!m_busy) begin
      pick = rr_pick(m_ptr, cand);
      if (pick >= 0) begin
        m_busy = 1'b1; m_grant = pick;
        grant_log.push_back(pick); grant_cyc.push_back(cyc);
      end
    end else if (hs) begin
      b = mem[m_grant][head[m_grant]];
      head[m_grant]++;
      beats_out++;
      if (b.last) begin
        m_busy = 1'b0; m_ptr = (m_grant + 1) % NQ; m_sent = 1'b1; m_sent_id = m_grant;
      end
    end
    #1;
    drive();
  endtask

  task automatic run_until_idle(int max_steps, output int used);
    used = 0;
    while ((m_busy || !all_empty()) && used < max_steps) begin step(); used++; end
    checks++;
    if (m_busy || !all_empty()) begin
      errors++; $display("FAIL drain_timeout: got busy=%b after %0d cycles expected drained", m_busy, used);
    end
  endtask

  task automatic start_test(logic [NQ-1:0] en);
    axis_resetn = 1'b0;
    model_reset();
    en_knob = en; tready_knob = 1'b1; tready_rand = 1'b0; gap_pct = 0;
    drive();
    @(posedge clk); #1;
    axis_resetn = 1'b1;
    repeat (4) step();
  endtask

  task automatic check_log(string name, int exp[]);
    checks++;
    if (grant_log.size() != exp.size()) begin
      errors++; $display("FAIL %s_len: got %0d grants expected %0d", name, grant_log.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (grant_log[i] != exp[i]) begin
          errors++; $display("FAIL %s[%0d]: got q%0d expected q%0d", name, i, grant_log[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    axis_resetn = 1'b0;
    model_reset();
    push_pkt(1, 2);
    drive();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (s_axis_tready !== '0 || m_axis_tvalid !== 1'b0 || grant_id !== '0 ||
        pkt_sent !== 1'b0 || pkt_sent_id !== '0 || m_axis_tdata !== '0) begin
      errors++; $display("FAIL reset_state: got ready=%b valid=%b grant=%0d sent=%b id=%0d expected all zero",
                         s_axis_tready, m_axis_tvalid, grant_id, pkt_sent, pkt_sent_id);
    end
  endtask

  task automatic test_single();
    int used;
    start_test(4'hF);
    push_pkt(2, 3);
    drive();
    run_until_idle(20, used);
    checks++;
    if (used != 4) begin errors++; $display("FAIL single_latency: got %0d cycles expected 4", used); end
    checks++;
    if (pkt_sent !== 1'b1 || pkt_sent_id !== 3'd2) begin
      errors++; $display("FAIL single_pkt_sent: got %b id %0d expected 1 id 2", pkt_sent, pkt_sent_id);
    end
    step(); step();
    check_log("single_order", '{2});
  endtask

  task automatic test_all_queues();
    int used;
    start_test(4'hF);
    for (int p = 0; p < 2; p++) for (int q = 0; q < NQ; q++) push_pkt(q, 2);
    drive();
    run_until_idle(100, used);
    step();
    checks++;
    if (used != 24) begin errors++; $display("FAIL all_q_cycles: got %0d expected 24", used); end
    check_log("all_q_order", '{0, 1, 2, 3, 0, 1, 2, 3});
    for (int i = 1; i < grant_cyc.size(); i++) begin
      checks++;
      if (grant_cyc[i] - grant_cyc[i-1] != 3) begin
        errors++; $display("FAIL all_q_spacing[%0d]: got %0d expected 3", i, grant_cyc[i] - grant_cyc[i-1]);
      end
    end
  endtask

  task automatic test_masking();
    start_test(4'b1010);
    for (int p = 0; p < 3; p++) for (int q = 0; q < NQ; q++) push_pkt(q, 2);
    drive();
    for (int i = 0; i < 40; i++) begin
      step();
      if (grant_log.size() == 3 && m_busy && en_knob[1]) begin
        en_knob = 4'b1000; queue_en = en_knob;
      end
    end
    check_log("mask_order", '{1, 3, 1, 3, 3});
  endtask

  task automatic test_backpressure();
    int used, base, guard;
    start_test(4'hF);
    push_pkt(0, 4); push_pkt(1, 2);
    drive();
    base = beats_out; guard = 0;
    while (beats_out - base < 1 && guard < 20) begin step(); guard++; end
    tready_knob = 1'b0; m_axis_tready = 1'b0;
    repeat (5) step();
    checks++;
    if (grant_id !== 3'd0 || beats_out - base != 1) begin
      errors++; $display("FAIL bp_hold: got grant %0d beats %0d expected grant 0 beats 1", grant_id, beats_out - base);
    end
    tready_knob = 1'b1; m_axis_tready = 1'b1;
    run_until_idle(40, used);
    step();
    checks++;
    if (beats_out - base != 6) begin errors++; $display("FAIL bp_beats: got %0d expected 6", beats_out - base); end
    check_log("bp_order", '{0, 1});
  endtask

  task automatic test_reset_mid();
    int used, base, guard;
    start_test(4'hF);
    push_pkt(2, 2);
    drive();
    run_until_idle(20, used);
    step();
    push_pkt(0, 4);
    drive();
    base = beats_out; guard = 0;
    while (beats_out - base < 1 && guard < 20) begin step(); guard++; end
    #2;
    axis_resetn = 1'b0;
    #1;
    checks++;
    if (s_axis_tready !== '0 || m_axis_tvalid !== 1'b0 || pkt_sent !== 1'b0 || pkt_sent_id !== '0) begin
      errors++; $display("FAIL reset_mid_async: got ready=%b valid=%b sent=%b id=%0d expected all zero",
                         s_axis_tready, m_axis_tvalid, pkt_sent, pkt_sent_id);
    end
    model_reset();
    drive();
    @(posedge clk); #1;
    axis_resetn = 1'b1;
    repeat (4) step();
    push_pkt(3, 2); push_pkt(1, 1);
    drive();
    run_until_idle(30, used);
    step();
    check_log("reset_mid_order", '{1, 3});
  endtask

  task automatic test_wrap();
    int used;
    start_test(4'hF);
    push_pkt(3, 2);
    drive();
    run_until_idle(20, used);
    push_pkt(0, 1); push_pkt(3, 1);
    drive();
    run_until_idle(20, used);
    step();
    check_log("wrap_order", '{3, 0, 3});
  endtask

  task automatic test_random();
    int used;
    start_test(4'hF);
    gap_pct = 20; tready_rand = 1'b1;
    for (int q = 0; q < NQ; q++) begin
      int n;
      n = int'($urandom_range(6, 1));
      for (int p = 0; p < n; p++) push_pkt(q, int'($urandom_range(5, 1)));
    end
    drive();
    run_until_idle(3000, used);
    step(); step();
    start_test(NQ'($urandom_range(15, 1)));
    gap_pct = 15; tready_rand = 1'b1;
    for (int q = 0; q < NQ; q++) for (int p = 0; p < 4; p++) push_pkt(q, int'($urandom_range(4, 1)));
    drive();
    repeat (300) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_all_queues();
    test_masking();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
